// File: rtl/exu_longpwb_if.sv
// exu_longpwb_if: completion inputs, OITF head view and regfile writeback port of the long-pipe writeback unit
interface exu_longpwb_if #(
    parameter int ITAG_WIDTH  = 1,
    parameter int XLEN        = 32,
    parameter int RFIDX_WIDTH = 5
);
    logic                   lsu_wbck_i_valid;
    logic                   lsu_wbck_i_ready;
    logic [ITAG_WIDTH-1:0]  lsu_wbck_i_itag;
    logic [XLEN-1:0]        lsu_wbck_i_wdat;
    logic                   lsu_wbck_i_err;
    logic                   muldiv_wbck_i_valid;
    logic                   muldiv_wbck_i_ready;
    logic [ITAG_WIDTH-1:0]  muldiv_wbck_i_itag;
    logic [XLEN-1:0]        muldiv_wbck_i_wdat;
    logic                   oitf_empty;
    logic [ITAG_WIDTH-1:0]  oitf_ret_ptr;
    logic [RFIDX_WIDTH-1:0] oitf_ret_rdidx;
    logic                   oitf_ret_rdwen;
    logic                   oitf_ret_ena;
    logic                   longp_wbck_o_valid;
    logic                   longp_wbck_o_ready;
    logic [XLEN-1:0]        longp_wbck_o_wdat;
    logic [RFIDX_WIDTH-1:0] longp_wbck_o_rdidx;
    logic                   longp_err_o;
    logic [ITAG_WIDTH-1:0]  longp_err_itag;

    modport master (
        output lsu_wbck_i_valid, lsu_wbck_i_itag, lsu_wbck_i_wdat, lsu_wbck_i_err,
        output muldiv_wbck_i_valid, muldiv_wbck_i_itag, muldiv_wbck_i_wdat,
        output oitf_empty, oitf_ret_ptr, oitf_ret_rdidx, oitf_ret_rdwen, longp_wbck_o_ready,
        input  lsu_wbck_i_ready, muldiv_wbck_i_ready, oitf_ret_ena,
        input  longp_wbck_o_valid, longp_wbck_o_wdat, longp_wbck_o_rdidx, longp_err_o, longp_err_itag
    );

    modport slave (
        input  lsu_wbck_i_valid, lsu_wbck_i_itag, lsu_wbck_i_wdat, lsu_wbck_i_err,
        input  muldiv_wbck_i_valid, muldiv_wbck_i_itag, muldiv_wbck_i_wdat,
        input  oitf_empty, oitf_ret_ptr, oitf_ret_rdidx, oitf_ret_rdwen, longp_wbck_o_ready,
        output lsu_wbck_i_ready, muldiv_wbck_i_ready, oitf_ret_ena,
        output longp_wbck_o_valid, longp_wbck_o_wdat, longp_wbck_o_rdidx, longp_err_o, longp_err_itag
    );
endinterface

// File: rtl/exu_longpwb.sv
// exu_longpwb: buffers out-of-order LSU/MULDIV completions per ITAG and retires them in OITF order
module exu_longpwb #(
    parameter int OITF_DEPTH  = 2,
    parameter int ITAG_WIDTH  = 1,
    parameter int XLEN        = 32,
    parameter int RFIDX_WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    exu_longpwb_if.slave     wb
);
    logic                   r_run;
    logic [OITF_DEPTH-1:0]  r_vld;
    logic [OITF_DEPTH-1:0]  r_err;
    logic [XLEN-1:0]        r_dat [OITF_DEPTH];
    logic [ITAG_WIDTH-1:0]  w_ptr;
    logic [RFIDX_WIDTH-1:0] w_rdidx;
    logic                   w_lsu_acc;
    logic                   w_mdv_acc;
    logic                   w_head_rdy;
    logic                   w_wbck_vld;
    logic                   w_ret;

    assign w_ptr   = wb.oitf_ret_ptr;
    assign w_rdidx = wb.oitf_ret_rdidx;

    // r_run keeps the ready outputs low until the first clock after reset release
    assign wb.lsu_wbck_i_ready    = r_run & ~r_vld[wb.lsu_wbck_i_itag];
    assign wb.muldiv_wbck_i_ready = r_run & ~r_vld[wb.muldiv_wbck_i_itag]
                                  & ~(wb.lsu_wbck_i_valid & (wb.lsu_wbck_i_itag == wb.muldiv_wbck_i_itag));
    assign w_lsu_acc  = wb.lsu_wbck_i_valid & wb.lsu_wbck_i_ready;
    assign w_mdv_acc  = wb.muldiv_wbck_i_valid & wb.muldiv_wbck_i_ready;

    assign w_head_rdy = ~wb.oitf_empty & r_vld[w_ptr];
    assign w_wbck_vld = w_head_rdy & wb.oitf_ret_rdwen & ~r_err[w_ptr];
    assign w_ret      = w_head_rdy & (w_wbck_vld ? wb.longp_wbck_o_ready : 1'b1);

    assign wb.longp_wbck_o_valid = w_wbck_vld;
    assign wb.longp_wbck_o_wdat  = r_dat[w_ptr];
    assign wb.longp_wbck_o_rdidx = r_run ? w_rdidx : '0;
    assign wb.oitf_ret_ena       = w_ret;
    assign wb.longp_err_o        = w_ret & r_err[w_ptr];
    assign wb.longp_err_itag     = r_run ? w_ptr : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run <= 1'b0;
            r_vld <= '0;
            r_err <= '0;
            r_dat <= '{default: '0};
        end else begin
            r_run <= 1'b1;
            if (w_ret) r_vld[w_ptr] <= 1'b0;
            if (w_lsu_acc) begin
                r_vld[wb.lsu_wbck_i_itag] <= 1'b1;
                r_dat[wb.lsu_wbck_i_itag] <= wb.lsu_wbck_i_wdat;
                r_err[wb.lsu_wbck_i_itag] <= wb.lsu_wbck_i_err;
            end
            if (w_mdv_acc) begin
                r_vld[wb.muldiv_wbck_i_itag] <= 1'b1;
                r_dat[wb.muldiv_wbck_i_itag] <= wb.muldiv_wbck_i_wdat;
                r_err[wb.muldiv_wbck_i_itag] <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_exu_longpwb.sv
// tb_exu_longpwb: directed checks of accept, in-order retire, backpressure, faults, collisions and reset
module tb_exu_longpwb;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    exu_longpwb_if #(.ITAG_WIDTH(1), .XLEN(32), .RFIDX_WIDTH(5)) wb ();

    exu_longpwb #(.OITF_DEPTH(2), .ITAG_WIDTH(1), .XLEN(32), .RFIDX_WIDTH(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wb    (wb)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        wb.lsu_wbck_i_valid    = 0;
        wb.lsu_wbck_i_itag     = 0;
        wb.lsu_wbck_i_wdat     = 0;
        wb.lsu_wbck_i_err      = 0;
        wb.muldiv_wbck_i_valid = 0;
        wb.muldiv_wbck_i_itag  = 0;
        wb.muldiv_wbck_i_wdat  = 0;
        wb.oitf_empty          = 0;
        wb.oitf_ret_ptr        = 0;
        wb.oitf_ret_rdidx      = 5;
        wb.oitf_ret_rdwen      = 1;
        wb.longp_wbck_o_ready  = 1;

        // reset state
        tick; tick;
        chk("rst_lsu_rdy", wb.lsu_wbck_i_ready, 0);
        chk("rst_mdv_rdy", wb.muldiv_wbck_i_ready, 0);
        chk("rst_valid", wb.longp_wbck_o_valid, 0);
        chk("rst_ret", wb.oitf_ret_ena, 0);
        chk("rst_rdidx", wb.longp_wbck_o_rdidx, 0);
        chk("rst_wdat", wb.longp_wbck_o_wdat, 0);
        chk("rst_err", wb.longp_err_o, 0);
        rst_n = 1;
        #1;
        chk("rel_lsu_rdy", wb.lsu_wbck_i_ready, 0);
        tick;
        chk("run_lsu_rdy", wb.lsu_wbck_i_ready, 1);
        chk("run_valid", wb.longp_wbck_o_valid, 0);
        chk("run_ret", wb.oitf_ret_ena, 0);

        // simple load itag0
        wb.lsu_wbck_i_valid = 1; wb.lsu_wbck_i_itag = 0; wb.lsu_wbck_i_wdat = 32'hDEADBEEF;
        #1;
        chk("t1_lsu_rdy", wb.lsu_wbck_i_ready, 1);
        chk("t1_nobypass", wb.longp_wbck_o_valid, 0);
        tick;
        wb.lsu_wbck_i_valid = 0;
        chk("t1_valid", wb.longp_wbck_o_valid, 1);
        chk("t1_wdat", wb.longp_wbck_o_wdat, 32'hDEADBEEF);
        chk("t1_rdidx", wb.longp_wbck_o_rdidx, 5);
        chk("t1_ret", wb.oitf_ret_ena, 1);
        chk("t1_full_rdy", wb.lsu_wbck_i_ready, 0);
        tick;
        wb.oitf_ret_ptr = 1; wb.oitf_empty = 1;
        #1;
        chk("t1_ret_once", wb.oitf_ret_ena, 0);
        chk("t1_freed", wb.lsu_wbck_i_ready, 1);

        // out of order: head is itag1, MULDIV itag0 first, LSU itag1 three cycles later
        wb.oitf_empty = 0; wb.oitf_ret_ptr = 1; wb.oitf_ret_rdidx = 7;
        wb.muldiv_wbck_i_valid = 1; wb.muldiv_wbck_i_itag = 0; wb.muldiv_wbck_i_wdat = 32'h11;
        #1;
        chk("t2_mdv_rdy", wb.muldiv_wbck_i_ready, 1);
        tick;
        wb.muldiv_wbck_i_valid = 0;
        chk("t2_c1_valid", wb.longp_wbck_o_valid, 0);
        chk("t2_c1_ret", wb.oitf_ret_ena, 0);
        tick;
        chk("t2_c2_valid", wb.longp_wbck_o_valid, 0);
        tick;
        wb.lsu_wbck_i_valid = 1; wb.lsu_wbck_i_itag = 1; wb.lsu_wbck_i_wdat = 32'h22;
        #1;
        chk("t2_c3_valid", wb.longp_wbck_o_valid, 0);
        chk("t2_c3_ret", wb.oitf_ret_ena, 0);
        tick;
        wb.lsu_wbck_i_valid = 0;
        chk("t2_c4_valid", wb.longp_wbck_o_valid, 1);
        chk("t2_c4_wdat", wb.longp_wbck_o_wdat, 32'h22);
        chk("t2_c4_ret", wb.oitf_ret_ena, 1);
        tick;
        wb.oitf_ret_ptr = 0; wb.oitf_ret_rdidx = 9;
        #1;
        chk("t2_c5_valid", wb.longp_wbck_o_valid, 1);
        chk("t2_c5_wdat", wb.longp_wbck_o_wdat, 32'h11);
        chk("t2_c5_rdidx", wb.longp_wbck_o_rdidx, 9);
        chk("t2_c5_ret", wb.oitf_ret_ena, 1);
        tick;
        wb.oitf_empty = 1; wb.oitf_ret_ptr = 1;

        // backpressure
        wb.oitf_empty = 0; wb.oitf_ret_rdidx = 3; wb.longp_wbck_o_ready = 0;
        wb.lsu_wbck_i_valid = 1; wb.lsu_wbck_i_itag = 1; wb.lsu_wbck_i_wdat = 32'hCAFE0001;
        tick;
        wb.lsu_wbck_i_valid = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t3_bp_valid", wb.longp_wbck_o_valid, 1);
            chk("t3_bp_wdat", wb.longp_wbck_o_wdat, 32'hCAFE0001);
            chk("t3_bp_rdidx", wb.longp_wbck_o_rdidx, 3);
            chk("t3_bp_ret", wb.oitf_ret_ena, 0);
            tick;
        end
        wb.longp_wbck_o_ready = 1;
        #1;
        chk("t3_rdy_ret", wb.oitf_ret_ena, 1);
        tick;
        wb.oitf_ret_ptr = 0; wb.oitf_empty = 1;

        // store retires without a write
        wb.oitf_empty = 0; wb.oitf_ret_rdwen = 0;
        wb.lsu_wbck_i_valid = 1; wb.lsu_wbck_i_itag = 0; wb.lsu_wbck_i_wdat = 32'h5;
        tick;
        wb.lsu_wbck_i_valid = 0;
        chk("t4_st_ret", wb.oitf_ret_ena, 1);
        chk("t4_st_valid", wb.longp_wbck_o_valid, 0);
        chk("t4_st_err", wb.longp_err_o, 0);
        tick;
        // faulted load
        wb.oitf_ret_ptr = 1; wb.oitf_ret_rdwen = 1;
        wb.lsu_wbck_i_valid = 1; wb.lsu_wbck_i_itag = 1; wb.lsu_wbck_i_wdat = 32'h9; wb.lsu_wbck_i_err = 1;
        tick;
        wb.lsu_wbck_i_valid = 0; wb.lsu_wbck_i_err = 0;
        chk("t4_err_ret", wb.oitf_ret_ena, 1);
        chk("t4_err_valid", wb.longp_wbck_o_valid, 0);
        chk("t4_err_o", wb.longp_err_o, 1);
        chk("t4_err_itag", wb.longp_err_itag, 1);
        tick;
        wb.oitf_ret_ptr = 0; wb.oitf_empty = 1;
        #1;
        chk("t4_err_clr", wb.longp_err_o, 0);

        // same-tag collision: LSU wins
        wb.lsu_wbck_i_valid = 1; wb.lsu_wbck_i_itag = 1; wb.lsu_wbck_i_wdat = 32'h55;
        wb.muldiv_wbck_i_valid = 1; wb.muldiv_wbck_i_itag = 1; wb.muldiv_wbck_i_wdat = 32'h66;
        #1;
        chk("t5_col_lsu_rdy", wb.lsu_wbck_i_ready, 1);
        chk("t5_col_mdv_rdy", wb.muldiv_wbck_i_ready, 0);
        tick;
        wb.muldiv_wbck_i_valid = 0; wb.lsu_wbck_i_wdat = 32'h77;
        #1;
        chk("t5_occ_lsu_rdy", wb.lsu_wbck_i_ready, 0);
        wb.oitf_empty = 0; wb.oitf_ret_ptr = 1;
        #1;
        chk("t5_win_wdat", wb.longp_wbck_o_wdat, 32'h55);
        chk("t5_ret", wb.oitf_ret_ena, 1);
        chk("t5_ret_cyc_rdy", wb.lsu_wbck_i_ready, 0);
        tick;
        wb.oitf_empty = 1;
        #1;
        chk("t5_after_ret_rdy", wb.lsu_wbck_i_ready, 1);
        wb.lsu_wbck_i_valid = 0;

        // dual accept with different tags
        wb.lsu_wbck_i_valid = 1; wb.lsu_wbck_i_itag = 0; wb.lsu_wbck_i_wdat = 32'hA0;
        wb.muldiv_wbck_i_valid = 1; wb.muldiv_wbck_i_itag = 1; wb.muldiv_wbck_i_wdat = 32'hB1;
        #1;
        chk("t5_dual_lsu_rdy", wb.lsu_wbck_i_ready, 1);
        chk("t5_dual_mdv_rdy", wb.muldiv_wbck_i_ready, 1);
        tick;
        wb.lsu_wbck_i_valid = 0; wb.muldiv_wbck_i_valid = 0;
        wb.oitf_empty = 0; wb.oitf_ret_ptr = 0;
        #1;
        chk("t5_dual_h0", wb.longp_wbck_o_wdat, 32'hA0);
        chk("t5_dual_r0", wb.oitf_ret_ena, 1);
        tick;
        wb.oitf_ret_ptr = 1;
        #1;
        chk("t5_dual_h1", wb.longp_wbck_o_wdat, 32'hB1);
        chk("t5_dual_r1", wb.oitf_ret_ena, 1);
        tick;
        wb.oitf_ret_ptr = 0; wb.oitf_empty = 1;

        // reset mid-operation
        wb.lsu_wbck_i_valid = 1; wb.lsu_wbck_i_itag = 0; wb.lsu_wbck_i_wdat = 32'h77;
        tick;
        wb.lsu_wbck_i_valid = 0; wb.lsu_wbck_i_itag = 1;
        wb.oitf_empty = 0; wb.longp_wbck_o_ready = 0;
        #1;
        chk("t6_pre_valid", wb.longp_wbck_o_valid, 1);
        chk("t6_pre_lsu_rdy", wb.lsu_wbck_i_ready, 1);
        chk("t6_pre_mdv_rdy", wb.muldiv_wbck_i_ready, 1);
        rst_n = 0;
        #1;
        chk("t6_rst_valid", wb.longp_wbck_o_valid, 0);
        chk("t6_rst_ret", wb.oitf_ret_ena, 0);
        chk("t6_rst_lsu_rdy", wb.lsu_wbck_i_ready, 0);
        chk("t6_rst_mdv_rdy", wb.muldiv_wbck_i_ready, 0);
        wb.longp_wbck_o_ready = 1;
        tick;
        rst_n = 1;
        tick;
        chk("t6_post_valid", wb.longp_wbck_o_valid, 0);
        chk("t6_post_ret", wb.oitf_ret_ena, 0);
        chk("t6_post_rdy", wb.lsu_wbck_i_ready, 1);
        tick;
        chk("t6_idle_ret", wb.oitf_ret_ena, 0);
        wb.lsu_wbck_i_valid = 1; wb.lsu_wbck_i_itag = 0; wb.lsu_wbck_i_wdat = 32'h88;
        tick;
        wb.lsu_wbck_i_valid = 0;
        chk("t6_new_valid", wb.longp_wbck_o_valid, 1);
        chk("t6_new_wdat", wb.longp_wbck_o_wdat, 32'h88);
        chk("t6_new_ret", wb.oitf_ret_ena, 1);
        tick;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/exu_longpwb.md
Name: exu_longpwb

Overview:
- Long-pipe writeback unit: the retire end of the OITF protocol.
- Collects out-of-order completions from the multicycle units (LSU, MULDIV), each tagged with the ITAG assigned at dispatch, and buffers them per ITAG.
- Writes results back in dispatch order at the OITF retire pointer through the final writeback arbiter.
- Pulses the OITF retire enable exactly once per retired entry.

Parameters:
OITF_DEPTH, 2, number of outstanding entries; equals OITF depth
ITAG_WIDTH, 1, ITAG width; log2(OITF_DEPTH), minimum 1
XLEN, 32, result data width
RFIDX_WIDTH, 5, register index width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
lsu_wbck_i_valid  in  1  LSU completion valid
lsu_wbck_i_ready  out  1  LSU completion accepted
lsu_wbck_i_itag  in  ITAG_WIDTH  LSU completion tag
lsu_wbck_i_wdat  in  XLEN  LSU load data
lsu_wbck_i_err  in  1  LSU access fault
muldiv_wbck_i_valid  in  1  MULDIV completion valid
muldiv_wbck_i_ready  out  1  MULDIV completion accepted
muldiv_wbck_i_itag  in  ITAG_WIDTH  MULDIV completion tag
muldiv_wbck_i_wdat  in  XLEN  MULDIV result
oitf_empty  in  1  OITF holds no entries
oitf_ret_ptr  in  ITAG_WIDTH  OITF retire pointer (head)
oitf_ret_rdidx  in  RFIDX_WIDTH  head entry destination register
oitf_ret_rdwen  in  1  head entry writes rd
oitf_ret_ena  out  1  retire head entry (one-cycle pulse)
longp_wbck_o_valid  out  1  regfile write request
longp_wbck_o_ready  in  1  write request granted by arbiter
longp_wbck_o_wdat  out  XLEN  write data
longp_wbck_o_rdidx  out  RFIDX_WIDTH  write register index
longp_err_o  out  1  head retired with fault (one-cycle pulse)
longp_err_itag  out  ITAG_WIDTH  ITAG of faulting entry

Behaviour:
- Result buffer: OITF_DEPTH entries, each holding res_vld, res_dat[XLEN] and res_err, all indexed by ITAG.
- Reset: all res_vld = 0 and all data/err registers = 0. Every output is 0 during and after reset (ready outputs and data outputs included).
- LSU accept:
  - lsu_wbck_i_ready = ~res_vld[lsu_itag].
  - On valid&ready, set entry lsu_itag: res_vld=1, dat=wdat, err=lsu_err.
- MULDIV accept:
  - muldiv_wbck_i_ready = ~res_vld[muldiv_itag] & ~(lsu_wbck_i_valid & lsu_itag==muldiv_itag). LSU wins a same-tag collision.
  - On accept, err=0.
- Readiness depends only on registered res_vld. An entry freed by retire in cycle N accepts a new completion no earlier than N+1.
- Both sources with different ITAGs are accepted in the same cycle.
- Head readiness: head_rdy = ~oitf_empty & res_vld[oitf_ret_ptr].
- No bypass: a completion accepted in cycle N is visible as head no earlier than N+1.
- Writeback path:
  - longp_wbck_o_valid = head_rdy & oitf_ret_rdwen & ~res_err[ret_ptr].
  - wdat = res_dat[ret_ptr]; rdidx = oitf_ret_rdidx.
- Retire:
  - oitf_ret_ena = head_rdy & (longp_wbck_o_valid ? longp_wbck_o_ready : 1).
  - Stores (rdwen=0) and faulted entries retire without a write request.
- Same-cycle clear: retire clears res_vld[ret_ptr] in the same cycle that oitf_ret_ena is asserted.
- Fault reporting: longp_err_o = oitf_ret_ena & res_err[ret_ptr]; longp_err_itag = oitf_ret_ptr.
- Handshake: once valid is asserted, valid/wdat/rdidx stay stable until ready. This is guaranteed because the head cannot change without a retire.
- Throughput: one retire per cycle maximum. Back-to-back retires of consecutive ITAGs are allowed, wrap-around included (DEPTH-1 -> 0).
- Illegal, unchecked stimulus: a completion for an ITAG not allocated in the OITF; a second completion for the same ITAG.
- Reset mid-operation clears all buffered results. Any pending write request is dropped without retire.

Test Plan:
- LSU load itag0, wdat=0xDEADBEEF, head rdidx=5 rdwen=1, arbiter ready=1 -> cycle after accept: valid=1, wdat=0xDEADBEEF, rdidx=5, oitf_ret_ena=1 for one cycle; res_vld[0]=0 next cycle.
- Out of order: MULDIV itag1 wdat=0x11 at cycle 0, LSU itag0 wdat=0x22 at cycle 3 -> no valid in cycles 1–3; cycle 4 writes 0x22; cycle 5 writes 0x11 (ret_ptr 1); ret_ena asserted in cycles 4 and 5.
- Backpressure: head ready with longp_wbck_o_ready=0 for 3 cycles -> valid held high, wdat/rdidx stable, ret_ena=0; ret_ena=1 in the cycle ready rises.
- Store (rdwen=0) and LSU err=1 load -> ret_ena pulses one cycle after accept with valid=0; the error case also asserts longp_err_o=1 with longp_err_itag equal to its ITAG.
- Same-tag collision and occupied entry:
  - LSU and MULDIV both valid, itag1 -> LSU accepted, muldiv ready=0.
  - LSU itag1 again while entry full -> lsu ready=0 until the cycle after retire.
- Reset mid-operation: rst_n low while valid=1 -> valid, ret_ena and both ready outputs drop to 0 immediately; after release, the buffer is empty and nothing retires until a new completion arrives.
